// File: rtl/if_stage_fetch_unit_pkg.sv
// if_stage_fetch_unit_pkg: shared FSM state type and default widths for the fetch front-end
package if_stage_fetch_unit_pkg;
  localparam int PC_W_DEF = 16;
  localparam int IMEM_AW_DEF = 8;
  localparam int INSTR_W_DEF = 32;
  localparam int RESET_PC_DEF = 0;
  typedef enum logic [1:0] {IDLE, BOOT, RUN} state_e;
endpackage

// File: rtl/if_stage_fetch_unit_if.sv
// if_stage_fetch_unit_if: synchronous single-port instruction SRAM bus
interface if_stage_fetch_unit_if #(
  parameter int IMEM_AW = if_stage_fetch_unit_pkg::IMEM_AW_DEF,
  parameter int INSTR_W = if_stage_fetch_unit_pkg::INSTR_W_DEF
);
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [INSTR_W-1:0] imem_rdata;
  modport master(output imem_we, imem_addr, imem_wdata, input imem_rdata);
  modport slave(input imem_we, imem_addr, imem_wdata, output imem_rdata);
endinterface

// File: rtl/if_stage_fetch_unit_pc_gen.sv
// if_stage_fetch_unit_pc_gen: PC register with increment/wrap, branch/stall select and issue enable
module if_stage_fetch_unit_pc_gen #(
  parameter int PC_W = if_stage_fetch_unit_pkg::PC_W_DEF,
  parameter int RESET_PC = if_stage_fetch_unit_pkg::RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            load,
  input  logic            boot_up,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            issue,
  output logic [PC_W-1:0] pc
);
  logic [PC_W-1:0] pc_q, pc_d;
  // a re-boot request outranks a redirect; wrap falls out of the PC_W-bit add
  always_comb begin
    issue = run && !boot_up && !stall && !branch_taken;
    pc_d = load ? PC_W'(RESET_PC) :
           (run && !boot_up && branch_taken) ? branch_target :
           issue ? pc_q + PC_W'(1) : pc_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= PC_W'(RESET_PC);
    else pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/if_stage_fetch_unit.sv
// if_stage_fetch_unit: boot loader, PC and 1-deep fetch pipeline; IF_PERF_CNT_EN adds fetch/squash counters
module if_stage_fetch_unit
  import if_stage_fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int IMEM_AW = IMEM_AW_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int BOOT_WORDS = 256,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 boot_up,
  input  logic                 boot_valid,
  input  logic [INSTR_W-1:0]   boot_data,
  output logic                 boot_ready,
  if_stage_fetch_unit_if.master imem,
  input  logic                 branch_taken,
  input  logic [PC_W-1:0]      branch_target,
  input  logic                 stall,
  output logic                 instr_valid,
  output logic [INSTR_W-1:0]   instr,
  output logic [PC_W-1:0]      instr_pc,
  output logic                 pc_run,
  output logic [PC_W-1:0]      pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_cnt,
  output logic [15:0]          squash_cnt
`endif
);
  state_e state_q, state_d;
  logic [IMEM_AW-1:0] cnt_q, cnt_d;
  logic rsp_v_q, rsp_v_d, hold_v_q, hold_v_d;
  logic [PC_W-1:0] rsp_pc_q, rsp_pc_d, hold_pc_q, hold_pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic run, load, issue, squash, enter_boot, capture;
  if_stage_fetch_unit_pc_gen #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc_gen (
    .clk(clk), .rst(rst), .run(run), .load(load), .boot_up(boot_up), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .issue(issue), .pc(pc)
  );
  always_comb begin
    run = state_q == RUN;
    boot_ready = state_q == BOOT;
    pc_run = run;
    load = boot_ready && boot_valid && cnt_q == IMEM_AW'(BOOT_WORDS - 1);
    enter_boot = boot_up && state_q != BOOT;
    squash = run && (boot_up || branch_taken);
    state_d = enter_boot ? BOOT : load ? RUN : state_q;
    cnt_d = enter_boot ? '0 : (boot_ready && boot_valid) ? cnt_q + IMEM_AW'(1) : cnt_q;
    rsp_v_d = issue;
    rsp_pc_d = issue ? pc : rsp_pc_q;
    // SRAM data is only valid for one cycle, so a stalled response is parked in the hold register
    capture = stall && !hold_v_q && rsp_v_q;
    hold_v_d = run && stall && !squash && (hold_v_q || rsp_v_q);
    hold_instr_d = capture ? imem.imem_rdata : hold_instr_q;
    hold_pc_d = capture ? rsp_pc_q : hold_pc_q;
    instr_valid = hold_v_q || rsp_v_q;
    instr = hold_v_q ? hold_instr_q : rsp_v_q ? imem.imem_rdata : '0;
    instr_pc = hold_v_q ? hold_pc_q : rsp_v_q ? rsp_pc_q : '0;
    imem.imem_we = boot_ready && boot_valid;
    imem.imem_addr = boot_ready ? cnt_q : pc[IMEM_AW-1:0];
    imem.imem_wdata = boot_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rsp_v_q <= 1'b0;
      rsp_pc_q <= '0;
      hold_v_q <= 1'b0;
      hold_pc_q <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rsp_v_q <= rsp_v_d;
      rsp_pc_q <= rsp_pc_d;
      hold_v_q <= hold_v_d;
      hold_pc_q <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] squash_cnt_q, squash_cnt_d;
  // a squash only loses an instruction that decode has not taken this cycle
  always_comb begin
    fetch_cnt_d = enter_boot ? '0 :
                  (instr_valid && !stall && fetch_cnt_q != '1) ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    squash_cnt_d = enter_boot ? '0 :
                   (squash && instr_valid && stall && squash_cnt_q != '1) ? squash_cnt_q + 16'd1 : squash_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_cnt_q <= '0;
      squash_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  assign fetch_cnt = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif
endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// tb_if_stage_fetch_unit: random + directed fetch stimulus against a presented/next-PC model with a delivery scoreboard
module tb_if_stage_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic boot_up = 0, boot_valid = 0, boot_ready, branch_taken = 0, stall = 0;
  logic instr_valid, pc_run;
  logic [31:0] boot_data = '0, instr;
  logic [7:0] branch_target = '0, instr_pc, pc;
  if_stage_fetch_unit_if #(.IMEM_AW(8), .INSTR_W(32)) imem ();
  if_stage_fetch_unit #(.PC_W(8), .IMEM_AW(8), .INSTR_W(32), .BOOT_WORDS(4), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .boot_up(boot_up), .boot_valid(boot_valid), .boot_data(boot_data),
    .boot_ready(boot_ready), .imem(imem), .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pc_run(pc_run), .pc(pc)
  );
  always #5 clk = ~clk;
  logic [31:0] sram [256];
  logic [31:0] ref_mem [256];
  always @(posedge clk) begin
    if (imem.imem_we) sram[imem.imem_addr] <= imem.imem_wdata;
    imem.imem_rdata <= sram[imem.imem_addr];
  end
  int nvec = 0, nerr = 0;
  logic [39:0] exp_q [$];
  int mst, mcnt;
  bit p;
  logic [7:0] mpc, ppc;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    nvec++;
    if (act !== ex) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    end
  endtask
  // model: mst 0=idle 1=boot 2=run; p/ppc = instruction presented this cycle; mpc = next PC to issue
  task automatic step(input bit bu, input bit bv, input logic [31:0] bd, input bit st, input bit br, input logic [7:0] tgt);
    @(posedge clk); #1;
    boot_up = bu; boot_valid = bv; boot_data = bd; stall = st; branch_taken = br; branch_target = tgt;
    #1;
    chk("boot_ready", boot_ready, mst == 1);
    chk("pc_run", pc_run, mst == 2);
    chk("instr_valid", instr_valid, p);
    if (p) begin
      chk("instr_pc", instr_pc, ppc);
      chk("instr", instr, ref_mem[ppc]);
    end
    if (mst == 1) begin
      chk("imem_we_boot", imem.imem_we, bv);
      if (bv) chk("imem_addr_boot", imem.imem_addr, mcnt);
    end
    if (mst == 2) begin
      chk("pc", pc, mpc);
      chk("imem_we_run", imem.imem_we, 0);
      if (!bu && !br && !st) chk("imem_addr_rd", imem.imem_addr, mpc);
    end
    case (mst)
      0: if (bu) begin mst = 1; mcnt = 0; end
      1: if (bv) begin
        ref_mem[mcnt] = bd;
        if (mcnt == 3) begin mst = 2; mpc = 8'h00; p = 0; end
        else mcnt++;
      end
      default: begin
        if (p && !st) exp_q.push_back({ppc, ref_mem[ppc]});
        if (bu) begin mst = 1; mcnt = 0; p = 0; end
        else if (br) begin mpc = tgt; p = 0; end
        else if (!st) begin p = 1; ppc = mpc; mpc = mpc + 8'd1; end
      end
    endcase
  endtask
  task automatic rst_pulse();
    @(posedge clk); #1;
    boot_up = 0; boot_valid = 0; stall = 0; branch_taken = 0;
    rst = 1'b1;
    #1;
    chk("rst_boot_ready", boot_ready, 0);
    chk("rst_pc_run", pc_run, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_pc", pc, 0);
    chk("rst_imem_we", imem.imem_we, 0);
    mst = 0; mcnt = 0; p = 0; mpc = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  always @(negedge clk)
    if (!rst && instr_valid && !stall) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL deliver: unexpected instr_pc %0h instr %0h, expected nothing", instr_pc, instr);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          nerr++;
          $display("FAIL deliver: got pc %0h instr %0h expected pc %0h instr %0h", instr_pc, instr, e[39:32], e[31:0]);
        end
      end
    end
  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    mst = 0; mcnt = 0; p = 0; mpc = 8'h00; ppc = 8'h00;
    rst_pulse();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hA000_00A0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 8'h33);
    step(0, 1, 32'hA000_00A1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'hA000_00A2, 0, 0, 0);
    step(0, 1, 32'hA000_00A3, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 8'h10);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8'hFF);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'hB000_0000 + i, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hC000_00C0, 0, 0, 0);
    step(0, 1, 32'hC000_00C1, 0, 0, 0);
    rst_pulse();
    repeat (2) step(0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      step(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 100 && mst != 2; k++)
        step(0, ($urandom % 3) != 0, $urandom, $urandom % 2, $urandom % 2, 8'($urandom));
      for (int k = 0; k < 400; k++)
        step(0, 0, 0, ($urandom % 10) < 3, ($urandom % 12) == 0, 8'($urandom));
    end
    repeat (3) step(0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
